// File: rtl/mdu_sequencer_if.sv
// Handshake/result bundle between E-stage control and the HI/LO multiply/divide unit.
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_req_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, hi_write, lo_write, a, b, md_req_d,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, hi_write, lo_write, a, b, md_req_d,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Fixed-latency multiply/divide sequencer owning HI/LO; results commit on the
// last busy cycle, and D-stage HI/LO-class instructions stall while occupied.
module mdu_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  mdu_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [1:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_busy;
  logic        w_commit_ok;

  // Sign/zero extension to 64 bits keeps the low 64 bits of the product exact for both forms.
  always_comb begin
    w_prod = '0;
    w_quot = '0;
    w_rem  = '0;
    if (r_op[0]) begin
      w_prod = {32'd0, r_opa} * {32'd0, r_opb};
    end else begin
      w_prod = {{32{r_opa[31]}}, r_opa} * {{32{r_opb[31]}}, r_opb};
    end
    if (r_opb != '0) begin
      if (r_op[0]) begin
        w_quot = r_opa / r_opb;
        w_rem  = r_opa % r_opb;
      end else begin
        w_quot = $signed(r_opa) / $signed(r_opb);
        w_rem  = $signed(r_opa) % $signed(r_opb);
      end
    end
  end

  always_comb begin
    w_res_hi    = w_prod[63:32];
    w_res_lo    = w_prod[31:0];
    w_commit_ok = 1'b1;
    if (r_state == S_DIV) begin
      w_res_hi    = w_rem;
      w_res_lo    = w_quot;
      w_commit_ok = (r_opb != '0);
    end
  end

  assign w_busy    = (r_state != S_IDLE);
  assign bus.busy  = w_busy;
  assign bus.stall = bus.md_req_d & (w_busy | bus.start);
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start (even a reserved op) drops any coincident mthi/mtlo.
          if (bus.start) begin
            if (!bus.op[2]) begin
              r_opa <= bus.a;
              r_opb <= bus.b;
              r_op  <= bus.op[1:0];
              if (bus.op[1]) begin
                r_cnt   <= 4'(DIV_CYCLES);
                r_state <= S_DIV;
              end else begin
                r_cnt   <= 4'(MUL_CYCLES);
                r_state <= S_MUL;
              end
            end
          end else begin
            if (bus.hi_write) r_hi <= bus.a;
            if (bus.lo_write) r_lo <= bus.a;
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt == 4'd1) begin
            if (w_commit_ok) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, results, priority, stall and reset abort.
module tb_mdu_sequencer;

  logic clk;
  logic reset;
  int unsigned n_tests;
  int unsigned n_fail;

  mdu_sequencer_if u_if ();

  mdu_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue in cycle 0, expect busy for exactly n cycles, then idle in cycle n+1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned n, input string tag);
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    u_if.a     = 32'hDEADBEEF;
    u_if.b     = 32'h0;
    for (int unsigned i = 0; i < n; i++) begin
      check_eq({tag, "_busy"}, 64'(u_if.busy), 64'd1);
      step();
    end
    check_eq({tag, "_done"}, 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    u_if.start     = 1'b0;
    u_if.op        = 3'd0;
    u_if.hi_write  = 1'b0;
    u_if.lo_write  = 1'b0;
    u_if.a         = '0;
    u_if.b         = '0;
    u_if.md_req_d  = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_busy",  64'(u_if.busy),  64'd0);
    check_eq("rst_stall", 64'(u_if.stall), 64'd0);
    check_eq("rst_hi",    64'(u_if.hi),    64'd0);
    check_eq("rst_lo",    64'(u_if.lo),    64'd0);

    run_op(3'd0, 32'hFFFFFFFF, 32'h2, 5, "mult");
    check_eq("mult_hi", 64'(u_if.hi), 64'hFFFFFFFF);
    check_eq("mult_lo", 64'(u_if.lo), 64'hFFFFFFFE);

    run_op(3'd1, 32'hFFFFFFFF, 32'h2, 5, "multu");
    check_eq("multu_hi", 64'(u_if.hi), 64'h1);
    check_eq("multu_lo", 64'(u_if.lo), 64'hFFFFFFFE);

    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 10, "div");
    check_eq("div_hi", 64'(u_if.hi), 64'hFFFFFFFF);
    check_eq("div_lo", 64'(u_if.lo), 64'hFFFFFFFD);

    run_op(3'd3, 32'd100, 32'd7, 10, "divu");
    check_eq("divu_hi", 64'(u_if.hi), 64'd2);
    check_eq("divu_lo", 64'(u_if.lo), 64'd14);

    u_if.a = 32'h11; u_if.hi_write = 1'b1;
    step();
    u_if.hi_write = 1'b0;
    check_eq("mthi", 64'(u_if.hi), 64'h11);
    u_if.a = 32'h22; u_if.lo_write = 1'b1;
    step();
    u_if.lo_write = 1'b0;
    check_eq("mtlo", 64'(u_if.lo), 64'h22);

    run_op(3'd3, 32'd7, 32'd0, 10, "divz");
    check_eq("divz_hi", 64'(u_if.hi), 64'h11);
    check_eq("divz_lo", 64'(u_if.lo), 64'h22);

    // Stall window with a HI write attempted mid-operation.
    u_if.md_req_d = 1'b1;
    u_if.op = 3'd0; u_if.a = 32'h00010000; u_if.b = 32'h00030000; u_if.start = 1'b1;
    #1;
    check_eq("stall_c0", 64'(u_if.stall), 64'd1);
    step();
    u_if.start = 1'b0;
    for (int unsigned c = 1; c <= 5; c++) begin
      u_if.hi_write = (c == 3);
      u_if.a        = (c == 3) ? 32'h1234 : 32'h0;
      #1;
      check_eq("stall_busy", 64'(u_if.stall), 64'd1);
      step();
    end
    u_if.hi_write = 1'b0;
    #1;
    check_eq("stall_drop", 64'(u_if.stall), 64'd0);
    check_eq("stall_hi",   64'(u_if.hi),    64'h3);
    check_eq("stall_lo",   64'(u_if.lo),    64'h0);
    u_if.md_req_d = 1'b0;

    // start wins over coincident mthi/mtlo.
    u_if.hi_write = 1'b1; u_if.lo_write = 1'b1;
    u_if.op = 3'd0; u_if.a = 32'd3; u_if.b = 32'd4; u_if.start = 1'b1;
    step();
    u_if.hi_write = 1'b0; u_if.lo_write = 1'b0; u_if.start = 1'b0;
    check_eq("prio_hi_nowr", 64'(u_if.hi), 64'h3);
    for (int unsigned c = 1; c < 5; c++) step();
    step();
    check_eq("prio_hi", 64'(u_if.hi), 64'd0);
    check_eq("prio_lo", 64'(u_if.lo), 64'd12);

    // Back-to-back issue in the first idle cycle.
    run_op(3'd1, 32'd6, 32'd7, 5, "b2b1");
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 5, "b2b2");
    check_eq("b2b_hi", 64'(u_if.hi), 64'hFFFFFFFF);
    check_eq("b2b_lo", 64'(u_if.lo), 64'hFFFFFFF1);

    // Both mthi and mtlo in one cycle.
    u_if.a = 32'hAB; u_if.hi_write = 1'b1; u_if.lo_write = 1'b1;
    step();
    u_if.hi_write = 1'b0; u_if.lo_write = 1'b0;
    check_eq("mtboth_hi", 64'(u_if.hi), 64'hAB);
    check_eq("mtboth_lo", 64'(u_if.lo), 64'hAB);

    // Reserved op is ignored.
    u_if.op = 3'd5; u_if.a = 32'd9; u_if.b = 32'd9; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    check_eq("rsv_busy", 64'(u_if.busy), 64'd0);
    check_eq("rsv_hi",   64'(u_if.hi),   64'hAB);

    // Reset in cycle 4 of a divide aborts without commit.
    u_if.op = 3'd3; u_if.a = 32'd100; u_if.b = 32'd7; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    for (int unsigned c = 1; c < 4; c++) step();
    reset = 1'b1;
    step();
    check_eq("abort_busy", 64'(u_if.busy), 64'd0);
    check_eq("abort_hi",   64'(u_if.hi),   64'd0);
    check_eq("abort_lo",   64'(u_if.lo),   64'd0);
    reset = 1'b0;
    for (int unsigned c = 0; c < 8; c++) step();
    check_eq("abort_nocommit_hi", 64'(u_if.hi), 64'd0);
    check_eq("abort_nocommit_lo", 64'(u_if.lo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
